// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite types, widths, response codes and FSM state encoding.
// Contents: ADDR_WIDTH/DATA_WIDTH/STRB_WIDTH, BUFFER_SIZE and MEM_AW,
// resp_t codes, addr_t/data_t/strb_t, state_type, rd_beat_t, addr_in_range().
package axi_lite_pkg;

  localparam int unsigned ADDR_WIDTH  = 32;
  localparam int unsigned DATA_WIDTH  = 8;
  localparam int unsigned STRB_WIDTH  = DATA_WIDTH / 8;
  localparam int unsigned BUFFER_SIZE = 4096;
  localparam int unsigned MEM_AW      = $clog2(BUFFER_SIZE);

  typedef logic [ADDR_WIDTH-1:0] addr_t;
  typedef logic [DATA_WIDTH-1:0] data_t;
  typedef logic [STRB_WIDTH-1:0] strb_t;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RADDR = 3'd1,
    RDATA = 3'd2,
    WADDR = 3'd3,
    WDATA = 3'd4,
    WRESP = 3'd5
  } state_type;

  // One read-data beat as seen on the R channel
  typedef struct packed {
    data_t data;
    resp_t resp;
  } rd_beat_t;

  // In range only when every bit above the memory index is zero (no aliasing)
  function automatic logic addr_in_range(input addr_t addr);
    return addr[ADDR_WIDTH-1:MEM_AW] == '0;
  endfunction

endpackage

// File: rtl/axi_lite_mem_slave_if.sv
// AXI4-Lite bus bundle (AR/R/AW/W/B channels).
// Modports: master drives addresses/data/valids and R/B readies;
// slave drives AR/AW/W readies, R data/resp/valid and B resp/valid.
interface axi_lite_mem_slave_if;

  axi_lite_pkg::addr_t ARADDR;
  logic                ARVALID;
  logic                ARREADY;
  axi_lite_pkg::data_t RDATA;
  axi_lite_pkg::resp_t RRESP;
  logic                RVALID;
  logic                RREADY;
  axi_lite_pkg::addr_t AWADDR;
  logic                AWVALID;
  logic                AWREADY;
  axi_lite_pkg::data_t WDATA;
  axi_lite_pkg::strb_t WSTRB;
  logic                WVALID;
  logic                WREADY;
  axi_lite_pkg::resp_t BRESP;
  logic                BVALID;
  logic                BREADY;

  modport master (
    output ARADDR, ARVALID, RREADY, AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY,
    input  ARREADY, RDATA, RRESP, RVALID, AWREADY, WREADY, BRESP, BVALID
  );

  modport slave (
    input  ARADDR, ARVALID, RREADY, AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY,
    output ARREADY, RDATA, RRESP, RVALID, AWREADY, WREADY, BRESP, BVALID
  );

endinterface

// File: rtl/axi_lite_slv_mem.sv
// Byte-wide backing store: synchronous write, combinational read.
// Ports: i_clk, i_we, i_waddr, i_wdata (write port); i_raddr, o_rdata_c (read port).
// Contents are never reset.
module axi_lite_slv_mem
  import axi_lite_pkg::*;
#(
  parameter int unsigned MEM_DEPTH = BUFFER_SIZE,
  parameter int unsigned IDX_W     = $clog2(MEM_DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_we,
  input  logic [IDX_W-1:0] i_waddr,
  input  data_t            i_wdata,
  input  logic [IDX_W-1:0] i_raddr,
  output data_t            o_rdata_c
);

  data_t r_mem [MEM_DEPTH];

  // Write port
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Read port, registered by the parent
  assign o_rdata_c = r_mem[i_raddr];

endmodule

// File: rtl/axi_lite_mem_slave.sv
// AXI4-Lite memory slave: one transaction at a time through a single FSM.
// Ports: ACLK, ARESETN (synchronous, active-low), io_axi (slave modport).
// Out-of-range addresses answer RESP_DECERR; all bus outputs are registered.
// Optional AXI_LITE_SLV_RR_ARB_EN: round-robin read/write arbitration in IDLE
// (default build: fixed read priority).
module axi_lite_mem_slave
  import axi_lite_pkg::*;
(
  input  logic                  ACLK,
  input  logic                  ARESETN,
  axi_lite_mem_slave_if.slave   io_axi
);

  localparam int unsigned MEM_DEPTH = BUFFER_SIZE;

  state_type r_state, w_state_nxt;
  addr_t     r_addr, w_addr_nxt;
  data_t     r_rdata, w_rdata_nxt;
  resp_t     r_rresp, w_rresp_nxt;
  resp_t     r_bresp, w_bresp_nxt;
  logic      r_arready, r_rvalid, r_awready, r_wready, r_bvalid;
  logic      w_grant_rd, w_grant_wr;
  logic      w_mem_we;
  data_t     w_mem_rdata;

  axi_lite_slv_mem #(
    .MEM_DEPTH (MEM_DEPTH),
    .IDX_W     (MEM_AW)
  ) u_mem (
    .i_clk     (ACLK),
    .i_we      (w_mem_we),
    .i_waddr   (r_addr[MEM_AW-1:0]),
    .i_wdata   (io_axi.WDATA),
    .i_raddr   (io_axi.ARADDR[MEM_AW-1:0]),
    .o_rdata_c (w_mem_rdata)
  );

`ifdef AXI_LITE_SLV_RR_ARB_EN
  // 1 = write granted last; reset value lets the first contention go to read
  logic r_last_grant;

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      r_last_grant <= 1'b1;
    end else if (w_grant_rd) begin
      r_last_grant <= 1'b0;
    end else if (w_grant_wr) begin
      r_last_grant <= 1'b1;
    end
  end
`endif

  // Next-state, datapath next values and memory write enable
  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_addr;
    w_rdata_nxt = r_rdata;
    w_rresp_nxt = r_rresp;
    w_bresp_nxt = r_bresp;
    w_mem_we    = 1'b0;
    w_grant_rd  = 1'b0;
    w_grant_wr  = 1'b0;

    unique case (r_state)
      IDLE: begin
`ifdef AXI_LITE_SLV_RR_ARB_EN
        w_grant_rd = io_axi.ARVALID && (!io_axi.AWVALID || r_last_grant);
`else
        w_grant_rd = io_axi.ARVALID;
`endif
        w_grant_wr = io_axi.AWVALID && !w_grant_rd;
        if (w_grant_rd) begin
          w_state_nxt = RADDR;
        end else if (w_grant_wr) begin
          w_state_nxt = WADDR;
        end
      end
      RADDR: begin
        if (io_axi.ARVALID) begin
          w_addr_nxt  = io_axi.ARADDR;
          w_state_nxt = RDATA;
          if (addr_in_range(io_axi.ARADDR)) begin
            w_rdata_nxt = w_mem_rdata;
            w_rresp_nxt = RESP_OKAY;
          end else begin
            w_rdata_nxt = '0;
            w_rresp_nxt = RESP_DECERR;
          end
        end
      end
      RDATA: begin
        if (io_axi.RREADY) begin
          w_state_nxt = IDLE;
        end
      end
      WADDR: begin
        if (io_axi.AWVALID) begin
          w_addr_nxt  = io_axi.AWADDR;
          w_state_nxt = WDATA;
        end
      end
      WDATA: begin
        if (io_axi.WVALID) begin
          // Reset in the same cycle discards the write
          w_mem_we    = ARESETN && io_axi.WSTRB[0] && addr_in_range(r_addr);
          w_bresp_nxt = addr_in_range(r_addr) ? RESP_OKAY : RESP_DECERR;
          w_state_nxt = WRESP;
        end
      end
      WRESP: begin
        if (io_axi.BREADY) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State and registered bus outputs; handshake flags decode the next state
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      r_state   <= IDLE;
      r_addr    <= '0;
      r_rdata   <= '0;
      r_rresp   <= RESP_OKAY;
      r_bresp   <= RESP_OKAY;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_addr    <= w_addr_nxt;
      r_rdata   <= w_rdata_nxt;
      r_rresp   <= w_rresp_nxt;
      r_bresp   <= w_bresp_nxt;
      r_arready <= (w_state_nxt == RADDR);
      r_rvalid  <= (w_state_nxt == RDATA);
      r_awready <= (w_state_nxt == WADDR);
      r_wready  <= (w_state_nxt == WDATA);
      r_bvalid  <= (w_state_nxt == WRESP);
    end
  end

  assign io_axi.ARREADY = r_arready;
  assign io_axi.RDATA   = r_rdata;
  assign io_axi.RRESP   = r_rresp;
  assign io_axi.RVALID  = r_rvalid;
  assign io_axi.AWREADY = r_awready;
  assign io_axi.WREADY  = r_wready;
  assign io_axi.BRESP   = r_bresp;
  assign io_axi.BVALID  = r_bvalid;

endmodule

// File: tb/tb_axi_lite_mem_slave.sv
// Scoreboard bench for axi_lite_mem_slave: stimulus tasks queue the expected
// R/B beats, a negedge monitor pops and compares them on each handshake.
// Honours AXI_LITE_SLV_RR_ARB_EN for the contention expectations.
module tb_axi_lite_mem_slave;
  import axi_lite_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axi_lite_mem_slave_if bus ();

  axi_lite_mem_slave dut (
    .ACLK    (clk),
    .ARESETN (rst_n),
    .io_axi  (bus.slave)
  );

  int checks = 0;
  int errors = 0;
  rd_beat_t rq[$];
  resp_t    bq[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare every completed R/B handshake against the scoreboard
  always @(negedge clk) begin
    rd_beat_t rb;
    resp_t    br;
    if (rst_n && bus.RVALID && bus.RREADY) begin
      if (rq.size() == 0) begin
        check("r_unexpected", 32'(bus.RDATA), 32'hFFFF_FFFF);
      end else begin
        rb = rq.pop_front();
        check("rdata", 32'(bus.RDATA), 32'(rb.data));
        check("rresp", 32'(bus.RRESP), 32'(rb.resp));
      end
    end
    if (rst_n && bus.BVALID && bus.BREADY) begin
      if (bq.size() == 0) begin
        check("b_unexpected", 32'(bus.BRESP), 32'hFFFF_FFFF);
      end else begin
        br = bq.pop_front();
        check("bresp", 32'(bus.BRESP), 32'(br));
      end
    end
  end

  task automatic axi_read(input addr_t a, input data_t exp_d, input resp_t exp_r,
                          input int stall, input bit chk_lat);
    int n;
    rq.push_back('{data: exp_d, resp: exp_r});
    bus.ARADDR  = a;
    bus.ARVALID = 1'b1;
    n = 0;
    while (!bus.ARREADY && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check("arready", 32'(bus.ARREADY), 32'd1);
    if (chk_lat) check("arready_lat", 32'(n), 32'd1);
    @(posedge clk); #1; n++;
    bus.ARVALID = 1'b0;
    check("rvalid", 32'(bus.RVALID), 32'd1);
    if (chk_lat) check("rvalid_lat", 32'(n), 32'd2);
    repeat (stall) begin
      @(posedge clk); #1;
      check("rvalid_hold", 32'(bus.RVALID), 32'd1);
      check("rdata_hold", 32'(bus.RDATA), 32'(exp_d));
      check("rresp_hold", 32'(bus.RRESP), 32'(exp_r));
    end
    bus.RREADY = 1'b1;
    @(posedge clk); #1;
    bus.RREADY = 1'b0;
    check("rvalid_drop", 32'(bus.RVALID), 32'd0);
  endtask

  task automatic axi_write(input addr_t a, input data_t d, input strb_t s, input resp_t exp_b,
                           input int stall, input bit probe_ar);
    int n;
    bq.push_back(exp_b);
    bus.AWADDR  = a;
    bus.AWVALID = 1'b1;
    n = 0;
    while (!bus.AWREADY && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check("awready", 32'(bus.AWREADY), 32'd1);
    @(posedge clk); #1;
    bus.AWVALID = 1'b0;
    bus.WDATA   = d;
    bus.WSTRB   = s;
    bus.WVALID  = 1'b1;
    check("wready", 32'(bus.WREADY), 32'd1);
    @(posedge clk); #1;
    bus.WVALID = 1'b0;
    check("bvalid_lat", 32'(bus.BVALID), 32'd1);
    if (probe_ar) begin
      bus.ARADDR  = 32'h14;
      bus.ARVALID = 1'b1;
    end
    repeat (stall) begin
      @(posedge clk); #1;
      check("bvalid_hold", 32'(bus.BVALID), 32'd1);
      check("bresp_hold", 32'(bus.BRESP), 32'(exp_b));
      if (probe_ar) check("ar_stalled", 32'(bus.ARREADY), 32'd0);
    end
    bus.ARVALID = 1'b0;
    bus.BREADY  = 1'b1;
    @(posedge clk); #1;
    bus.BREADY = 1'b0;
    check("bvalid_drop", 32'(bus.BVALID), 32'd0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_arready"}, 32'(bus.ARREADY), 32'd0);
    check({tag, "_rvalid"},  32'(bus.RVALID),  32'd0);
    check({tag, "_awready"}, 32'(bus.AWREADY), 32'd0);
    check({tag, "_wready"},  32'(bus.WREADY),  32'd0);
    check({tag, "_bvalid"},  32'(bus.BVALID),  32'd0);
    check({tag, "_rdata"},   32'(bus.RDATA),   32'd0);
    check({tag, "_rresp"},   32'(bus.RRESP),   32'(RESP_OKAY));
    check({tag, "_bresp"},   32'(bus.BRESP),   32'(RESP_OKAY));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, k, cyc, g;
    int t[2];
    bit exp_g[4];
    bit got_g[4];

    bus.ARADDR = '0; bus.ARVALID = 1'b0; bus.RREADY = 1'b0;
    bus.AWADDR = '0; bus.AWVALID = 1'b0; bus.WDATA = '0;
    bus.WSTRB  = '0; bus.WVALID  = 1'b0; bus.BREADY = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic write/read with latency
    axi_write(32'h14, 8'hA5, 1'b1, RESP_OKAY, 0, 1'b0);
    axi_read(32'h14, 8'hA5, RESP_OKAY, 0, 1'b1);

    // WSTRB=0 leaves memory untouched
    axi_write(32'h4, 8'h5A, 1'b1, RESP_OKAY, 0, 1'b0);
    axi_write(32'h4, 8'h3C, 1'b0, RESP_OKAY, 0, 1'b0);
    axi_read(32'h4, 8'h5A, RESP_OKAY, 0, 1'b1);

    // Out of range, no aliasing onto 0x4
    axi_read(32'h1000, 8'h00, RESP_DECERR, 0, 1'b1);
    axi_write(32'h0001_0004, 8'hFF, 1'b1, RESP_DECERR, 0, 1'b0);
    axi_read(32'h4, 8'h5A, RESP_OKAY, 0, 1'b1);

    // Back-pressure on R and B, AR blocked while busy
    axi_read(32'h14, 8'hA5, RESP_OKAY, 5, 1'b1);
    axi_write(32'h40, 8'h99, 1'b1, RESP_OKAY, 5, 1'b1);
    axi_read(32'h40, 8'h99, RESP_OKAY, 0, 1'b1);

    // Back-to-back reads with RREADY tied high: one every 3 cycles
    rq.push_back('{data: 8'hA5, resp: RESP_OKAY});
    rq.push_back('{data: 8'hA5, resp: RESP_OKAY});
    bus.RREADY = 1'b1; bus.ARADDR = 32'h14; bus.ARVALID = 1'b1;
    k = 0; cyc = 0;
    while (k < 2 && cyc < 30) begin
      @(posedge clk); #1; cyc++;
      if (bus.RVALID) begin
        t[k] = cyc; k++;
        if (k == 2) bus.ARVALID = 1'b0;
      end
    end
    bus.ARVALID = 1'b0;
    check("b2b_count", 32'(k), 32'd2);
    check("b2b_period", 32'(t[1] - t[0]), 32'd3);
    @(posedge clk); #1;
    bus.RREADY = 1'b0;

    // Reset while waiting for W data: aborts, write discarded
    bus.AWADDR = 32'h14; bus.AWVALID = 1'b1;
    n = 0;
    while (!bus.AWREADY && n < 20) begin
      @(posedge clk); #1; n++;
    end
    @(posedge clk); #1;
    bus.AWVALID = 1'b0;
    bus.WDATA   = 8'h77;
    check("abort_wready", 32'(bus.WREADY), 32'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check_idle_outputs("abort");
    @(posedge clk); #1;
    check("abort_stay_idle", 32'(bus.AWREADY | bus.WREADY | bus.ARREADY), 32'd0);

    // Contention with both requests held: fixed priority or round-robin
    for (int i = 0; i < 4; i++) begin
`ifdef AXI_LITE_SLV_RR_ARB_EN
      exp_g[i] = (i % 2 == 0);
`else
      exp_g[i] = 1'b1;
`endif
      if (exp_g[i]) rq.push_back('{data: 8'hA5, resp: RESP_OKAY});
      else          bq.push_back(RESP_OKAY);
    end
    bus.ARADDR = 32'h14; bus.AWADDR = 32'h30; bus.WDATA = 8'h66; bus.WSTRB = 1'b1;
    bus.WVALID = 1'b1; bus.RREADY = 1'b1; bus.BREADY = 1'b1;
    bus.ARVALID = 1'b1; bus.AWVALID = 1'b1;
    g = 0; n = 0;
    while (g < 4 && n < 80) begin
      @(posedge clk); #1; n++;
      if (bus.ARREADY || bus.AWREADY) begin
        got_g[g] = bus.ARREADY;
        g++;
        if (g == 4) begin
          if (bus.ARREADY) bus.AWVALID = 1'b0;
          else             bus.ARVALID = 1'b0;
          @(posedge clk); #1;
        end
      end
    end
    bus.ARVALID = 1'b0; bus.AWVALID = 1'b0;
    check("grant_count", 32'(g), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("grant%0d_is_read", i), 32'(got_g[i]), 32'(exp_g[i]));
    end
    repeat (4) @(posedge clk);
    #1;
    bus.WVALID = 1'b0; bus.RREADY = 1'b0; bus.BREADY = 1'b0;

    // Aborted write left 0x14 intact
    axi_read(32'h14, 8'hA5, RESP_OKAY, 0, 1'b1);
`ifdef AXI_LITE_SLV_RR_ARB_EN
    axi_read(32'h30, 8'h66, RESP_OKAY, 0, 1'b1);
`endif

    n = 0;
    while ((rq.size() != 0 || bq.size() != 0) && n < 20) begin
      @(posedge clk); n++;
    end
    check("rq_drained", 32'(rq.size()), 32'd0);
    check("bq_drained", 32'(bq.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
